// File: rtl/cv_bus_pkg.sv
// Purpose: shared system-bus command codes, bus widths and arbiter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cv_bus_pkg;

  // System-bus command codes carried on S_CMD
  localparam logic [2:0] SCMD_WRLED = 3'b000;
  localparam logic [2:0] SCMD_WR    = 3'b001;
  localparam logic [2:0] SCMD_RD    = 3'b100;

  // Default bus widths
  localparam int ADDR_W = 40;
  localparam int DATA_W = 8;

  // Arbiter ownership state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cv_rr_pick.sv
// Purpose: rotating priority encoder, first set request at or after ptr (mod N).
// Latency: purely combinational.
// Backpressure: none; valid=0 when no request is set.
module cv_rr_pick
  import cv_bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] pick,
  output logic          valid
);

  // Scan from the farthest offset back toward ptr so the nearest request wins
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        pick  = IW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cv_sys_bus_arbiter.sv
// Purpose: round-robin sharing of one system-bus slave among N_MST masters, grant locked while owner holds REQ.
// Latency: REQ seen at edge k drives S_EX_REQ during cycle k+1; one dead IDLE cycle after each release.
// Backpressure: non-owners simply wait with REQ high; a silent slave is cut off by the watchdog (M_EX_ERR pulse).
module cv_sys_bus_arbiter
  import cv_bus_pkg::*;
#(
  parameter int N_MST  = 4,
  parameter int ADDR_W = cv_bus_pkg::ADDR_W,
  parameter int DATA_W = cv_bus_pkg::DATA_W,
  parameter int TMO    = 255
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_MST-1:0]           M_EX_REQ,
  input  logic [N_MST*ADDR_W-1:0]    M_ADDR,
  input  logic [N_MST*3-1:0]         M_CMD,
  input  logic [N_MST*DATA_W-1:0]    M_D_WR,
  output logic [N_MST-1:0]           M_EX_ACK,
  output logic [N_MST-1:0]           M_EX_ERR,
  output logic [DATA_W-1:0]          M_D_RD,
  output logic                       S_EX_REQ,
  output logic [ADDR_W-1:0]          S_ADDR,
  output logic [2:0]                 S_CMD,
  output logic [DATA_W-1:0]          S_D_WR,
  input  logic                       S_EX_ACK,
  input  logic [DATA_W-1:0]          S_D_RD,
  output logic [$clog2(N_MST)-1:0]   GNT_ID,
  output logic                       BUSY
);

  localparam int GW = $clog2(N_MST);
  // Counter wide enough to hold TMO-1 for any TMO including 0
  localparam int TW = $clog2(TMO + 2);

  arb_state_t      state;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   ptr_next;
  logic            pick_vld;
  logic [TW-1:0]   tmo_cnt;
  logic            own;
  logic            owner_req;
  logic            tmo_hit;

  assign own       = (state == ST_OWN);
  assign owner_req = M_EX_REQ[gnt];
  // An ACK in the last watchdog cycle wins, so the hit requires no ACK
  assign tmo_hit   = (TMO > 0) && !S_EX_ACK && (tmo_cnt == TW'(TMO - 1));
  assign ptr_next  = (pick == GW'(N_MST - 1)) ? '0 : pick + 1'b1;

  cv_rr_pick #(
    .N  (N_MST),
    .IW (GW)
  ) u_pick (
    .req   (M_EX_REQ),
    .ptr   (ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Ownership FSM: arbitrate in IDLE, hold grant in OWN until REQ drops or watchdog fires
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      ptr     <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt     <= pick;
            ptr     <= ptr_next;
            state   <= ST_OWN;
            tmo_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (!owner_req) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else if (S_EX_ACK) begin
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Route the owner's fields to the slave and the slave's ACK/timeout back to the owner only
  always_comb begin
    S_EX_REQ = 1'b0;
    S_ADDR   = '0;
    S_CMD    = '0;
    S_D_WR   = '0;
    M_EX_ACK = '0;
    M_EX_ERR = '0;
    if (own) begin
      S_EX_REQ      = owner_req;
      S_ADDR        = M_ADDR[int'(gnt)*ADDR_W +: ADDR_W];
      S_CMD         = M_CMD[int'(gnt)*3 +: 3];
      S_D_WR        = M_D_WR[int'(gnt)*DATA_W +: DATA_W];
      M_EX_ACK[gnt] = S_EX_ACK;
      M_EX_ERR[gnt] = tmo_hit;
    end
  end

  assign M_D_RD = S_D_RD;
  assign GNT_ID = gnt;
  assign BUSY   = own;

  // Slave ACK is a single-cycle pulse per request phase
  ack_single_pulse: assert property (@(posedge CLK) disable iff (RST)
    (S_EX_ACK && S_EX_REQ) |=> !S_EX_ACK);

endmodule

// File: tb/tb_cv_sys_bus_arbiter.sv
module tb_cv_sys_bus_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic [3:0]  M_EX_REQ;
  logic [159:0] M_ADDR;
  logic [11:0] M_CMD;
  logic [31:0] M_D_WR;
  logic [3:0]  M_EX_ACK;
  logic [3:0]  M_EX_ERR;
  logic [7:0]  M_D_RD;
  logic        S_EX_REQ;
  logic [39:0] S_ADDR;
  logic [2:0]  S_CMD;
  logic [7:0]  S_D_WR;
  logic        S_EX_ACK;
  logic [7:0]  S_D_RD;
  logic [1:0]  GNT_ID;
  logic        BUSY;

  always #5 clk = ~clk;

  cv_sys_bus_arbiter #(
    .N_MST (4),
    .ADDR_W(40),
    .DATA_W(8),
    .TMO   (8)
  ) dut (
    .CLK     (clk),
    .RST     (RST),
    .M_EX_REQ(M_EX_REQ),
    .M_ADDR  (M_ADDR),
    .M_CMD   (M_CMD),
    .M_D_WR  (M_D_WR),
    .M_EX_ACK(M_EX_ACK),
    .M_EX_ERR(M_EX_ERR),
    .M_D_RD  (M_D_RD),
    .S_EX_REQ(S_EX_REQ),
    .S_ADDR  (S_ADDR),
    .S_CMD   (S_CMD),
    .S_D_WR  (S_D_WR),
    .S_EX_ACK(S_EX_ACK),
    .S_D_RD  (S_D_RD),
    .GNT_ID  (GNT_ID),
    .BUSY    (BUSY)
  );

  // One record per clock cycle: inputs applied in that cycle and outputs expected in it
  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         ack;
    logic [7:0] drd;
    bit         rmw2;
    bit         exp_sreq;
    logic [3:0] exp_ack;
    logic [3:0] exp_err;
    logic [1:0] exp_gnt;
    bit         exp_busy;
    int         exp_fld;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [39:0] addr_m[4];
  logic [2:0]  cmd_m[4];
  logic [7:0]  dwr_m[4];

  task automatic add(input bit rst, input logic [3:0] req, input bit ack, input logic [7:0] drd,
                     input bit rmw2, input bit sreq, input logic [3:0] mack, input logic [3:0] merr,
                     input logic [1:0] gnt, input bit busy, input int fld);
    vec_t v;
    v.rst = rst; v.req = req; v.ack = ack; v.drd = drd; v.rmw2 = rmw2;
    v.exp_sreq = sreq; v.exp_ack = mack; v.exp_err = merr; v.exp_gnt = gnt;
    v.exp_busy = busy; v.exp_fld = fld;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input bit rmw2);
    addr_m[0] = 40'h12_3456_789A; cmd_m[0] = 3'b001; dwr_m[0] = 8'h5A;
    addr_m[1] = 40'h00_0000_1111; cmd_m[1] = 3'b100; dwr_m[1] = 8'h11;
    addr_m[2] = 40'hAB_CDEF_0002; cmd_m[2] = 3'b100; dwr_m[2] = 8'h22;
    addr_m[3] = 40'hFF_0000_0003; cmd_m[3] = 3'b001; dwr_m[3] = 8'h33;
    if (rmw2) begin
      cmd_m[2] = 3'b000;
      dwr_m[2] = 8'h3F;
    end
    M_ADDR = {addr_m[3], addr_m[2], addr_m[1], addr_m[0]};
    M_CMD  = {cmd_m[3], cmd_m[2], cmd_m[1], cmd_m[0]};
    M_D_WR = {dwr_m[3], dwr_m[2], dwr_m[1], dwr_m[0]};
  endtask

  initial begin
    logic [3:0] err_seen;
    int         own_cycles;
    int         wait_cycles;
    bit         got_err;
    bit         got_busy;
    logic [39:0] e_addr;
    logic [2:0]  e_cmd;
    logic [7:0]  e_dwr;
    logic [3:0]  gbit;

    RST = 1'b1; M_EX_REQ = '0; S_EX_ACK = 1'b0; S_D_RD = '0;
    set_fields(1'b0);

    // ---- Reset state and single master ----
    add(1, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b0001, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b0001, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0001, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0001, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0001, 1, 8'h00, 0, 1, 4'b0001, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);

    // ---- Round robin with all four requesting: 0,1,2,3,0 ----
    add(1, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    for (int k = 0; k < 5; k++) begin
      gbit = 4'b0001 << (k % 4);
      add(0, 4'b1111, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, (k == 0) ? 2'd0 : 2'((k - 1) % 4), 0, -1);
      add(0, 4'b1111, 1, 8'h00, 0, 1, gbit, 4'b0000, 2'(k % 4), 1, k % 4);
      add(0, 4'b1111 & ~gbit, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 2'(k % 4), 1, k % 4);
    end

    // ---- REQ=1010 from reset: 1, 3, 1 ----
    add(1, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b1010, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b1010, 1, 8'h00, 0, 1, 4'b0010, 4'b0000, 1, 1, 1);
    add(0, 4'b1000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 1, 1, 1);
    add(0, 4'b1010, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 1, 0, -1);
    add(0, 4'b1010, 1, 8'h00, 0, 1, 4'b1000, 4'b0000, 3, 1, 3);
    add(0, 4'b0010, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 3, 1, 3);
    add(0, 4'b1010, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 3, 0, -1);
    add(0, 4'b1010, 1, 8'h00, 0, 1, 4'b0010, 4'b0000, 1, 1, 1);
    add(0, 4'b1000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 1, 1, 1);

    // ---- Atomic RMW by M2 while M0/M1 wait ----
    add(1, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 1, 0, -1);
    add(0, 4'b0100, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b0111, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 2, 1, 2);
    add(0, 4'b0111, 1, 8'h0F, 0, 1, 4'b0100, 4'b0000, 2, 1, 2);
    add(0, 4'b0111, 0, 8'h00, 1, 1, 4'b0000, 4'b0000, 2, 1, 2);
    add(0, 4'b0111, 1, 8'h00, 1, 1, 4'b0100, 4'b0000, 2, 1, 2);
    add(0, 4'b0011, 0, 8'h00, 1, 0, 4'b0000, 4'b0000, 2, 1, 2);
    add(0, 4'b0011, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 2, 0, -1);
    add(0, 4'b0011, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);

    // ---- Watchdog: M1 never ACKed, pending M3 follows ----
    add(1, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b0010, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    for (int c = 1; c <= 8; c++)
      add(0, 4'b1010, 0, 8'h00, 0, 1, 4'b0000, (c == 8) ? 4'b0010 : 4'b0000, 1, 1, 1);
    add(0, 4'b1000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 1, 0, -1);
    for (int c = 1; c <= 7; c++)
      add(0, 4'b1000, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 3, 1, 3);
    // ACK in the 8th cycle beats the watchdog
    add(0, 4'b1000, 1, 8'h00, 0, 1, 4'b1000, 4'b0000, 3, 1, 3);
    add(0, 4'b1000, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 3, 1, 3);

    // ---- Reset while M3 owns, then REQ=1001 grants M0 ----
    add(1, 4'b1000, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 3, 1, 3);
    add(0, 4'b1001, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b1001, 0, 8'h00, 0, 1, 4'b0000, 4'b0000, 0, 1, 0);

    // ---- Stray ACK in IDLE ----
    add(0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 1, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(0, 4'b0000, 0, 8'h00, 0, 0, 4'b0000, 4'b0000, 0, 0, -1);

    repeat (2) @(posedge clk);

    foreach (vecs[r]) begin
      @(negedge clk);
      RST = vecs[r].rst; M_EX_REQ = vecs[r].req; S_EX_ACK = vecs[r].ack; S_D_RD = vecs[r].drd;
      set_fields(vecs[r].rmw2);
      #2;
      if (vecs[r].exp_fld < 0) begin
        e_addr = '0; e_cmd = '0; e_dwr = '0;
      end else begin
        e_addr = addr_m[vecs[r].exp_fld]; e_cmd = cmd_m[vecs[r].exp_fld]; e_dwr = dwr_m[vecs[r].exp_fld];
      end
      check($sformatf("row%0d s_ex_req", r), 64'(S_EX_REQ), 64'(vecs[r].exp_sreq));
      check($sformatf("row%0d m_ex_ack", r), 64'(M_EX_ACK), 64'(vecs[r].exp_ack));
      check($sformatf("row%0d m_ex_err", r), 64'(M_EX_ERR), 64'(vecs[r].exp_err));
      check($sformatf("row%0d gnt_id", r), 64'(GNT_ID), 64'(vecs[r].exp_gnt));
      check($sformatf("row%0d busy", r), 64'(BUSY), 64'(vecs[r].exp_busy));
      check($sformatf("row%0d s_addr", r), 64'(S_ADDR), 64'(e_addr));
      check($sformatf("row%0d s_cmd_dwr", r), 64'({S_CMD, S_D_WR}), 64'({e_cmd, e_dwr}));
      check($sformatf("row%0d m_d_rd", r), 64'(M_D_RD), 64'(vecs[r].drd));
    end

    // ---- Hand sequence: owner keeps REQ after timeout and drops to lowest priority ----
    @(negedge clk);
    RST = 1'b1; M_EX_REQ = '0; S_EX_ACK = 1'b0; S_D_RD = '0;
    set_fields(1'b0);
    @(negedge clk);
    RST = 1'b0; M_EX_REQ = 4'b0110;
    own_cycles = 0; got_err = 1'b0; err_seen = '0;
    for (int c = 0; c < 30 && !got_err; c++) begin
      @(negedge clk); #2;
      if (BUSY) own_cycles++;
      if (M_EX_ERR != 4'b0000) begin
        got_err  = 1'b1;
        err_seen = M_EX_ERR;
      end
    end
    check("wd_err_seen_within_budget", 64'(got_err), 64'(1));
    check("wd_err_owner_m1", 64'(err_seen), 64'(4'b0010));
    check("wd_own_cycles", 64'(own_cycles), 64'(8));
    @(negedge clk); #2;
    check("wd_dead_cycle_busy", 64'(BUSY), 64'(0));
    got_busy = 1'b0; wait_cycles = 0;
    for (int c = 0; c < 10 && !got_busy; c++) begin
      @(negedge clk); #2;
      wait_cycles++;
      if (BUSY) got_busy = 1'b1;
    end
    check("wd_regrant_within_budget", 64'(got_busy), 64'(1));
    check("wd_regrant_latency", 64'(wait_cycles), 64'(1));
    check("wd_regrant_to_m2", 64'(GNT_ID), 64'(2));
    @(negedge clk);
    M_EX_REQ = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
